// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - phase codes, lamp constants and decode helpers for tc_phase_scheduler (TC_PED_EN adds S_WALK)
package tc_pkg;

    localparam int PHASE_W = 3;
    localparam int LAMP_W  = 3;

    // Lamp encodings {red, yellow, green}
    localparam logic [LAMP_W-1:0] RED    = 3'b100;
    localparam logic [LAMP_W-1:0] YELLOW = 3'b010;
    localparam logic [LAMP_W-1:0] GREEN  = 3'b001;

    typedef enum logic [PHASE_W-1:0] {
        S_AG   = 3'd0,
        S_AY   = 3'd1,
        S_RA   = 3'd2,
        S_BG   = 3'd3,
        S_BY   = 3'd4,
`ifdef TC_PED_EN
        S_RB   = 3'd5,
        S_WALK = 3'd6
`else
        S_RB   = 3'd5
`endif
    } tc_state_e;

    // Street A lamp for a given phase; every phase that is not A's own is red
    function automatic logic [LAMP_W-1:0] lamp_a(input tc_state_e s);
        case (s)
            S_AG:    lamp_a = GREEN;
            S_AY:    lamp_a = YELLOW;
            default: lamp_a = RED;
        endcase
    endfunction

    // Street B lamp for a given phase
    function automatic logic [LAMP_W-1:0] lamp_b(input tc_state_e s);
        case (s)
            S_BG:    lamp_b = GREEN;
            S_BY:    lamp_b = YELLOW;
            default: lamp_b = RED;
        endcase
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tc_dwell_timer.sv
// rtl/tc_dwell_timer.sv - saturating dwell counter with synchronous clear
module tc_dwell_timer #(
    parameter int          CNT_W = 8,
    parameter int unsigned LIMIT = 7
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Clear on phase entry, otherwise count up and hold at LIMIT
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/tc_phase_scheduler.sv
// rtl/tc_phase_scheduler.sv - timed two-street phase scheduler; TC_PED_EN adds pedestrian walk phase
module tc_phase_scheduler
    import tc_pkg::*;
#(
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 8,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned WALK_T    = 3,
    parameter int          CNT_W     = 8
) (
    input  logic               CLK,
    input  logic               R,
    input  logic               T_A,
    input  logic               T_B,
`ifdef TC_PED_EN
    input  logic               P_REQ,
`endif
    output logic [LAMP_W-1:0]  L_A,
    output logic [LAMP_W-1:0]  L_B,
    output logic [PHASE_W-1:0] PHASE
`ifdef TC_PED_EN
    ,
    output logic               WALK
`endif
);

    // Counter holds at the longest dwell so no phase exit can be skipped by wrap or early saturation
    localparam int unsigned SAT = max4(GREEN_MAX, YELLOW_T, ALLRED_T, WALK_T) - 1;

    localparam logic [CNT_W-1:0] C_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] C_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] C_YEL  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] C_RED  = CNT_W'(ALLRED_T - 1);
`ifdef TC_PED_EN
    localparam logic [CNT_W-1:0] C_WALK = CNT_W'(WALK_T - 1);
`endif

    tc_state_e        r_state;
    tc_state_e        w_next;
    logic [CNT_W-1:0] w_cnt;
    logic             w_clr;
    logic             w_dem_a;
    logic             w_dem_b;
    logic             w_ped;
    logic [LAMP_W-1:0] r_l_a;
    logic [LAMP_W-1:0] r_l_b;
    logic [PHASE_W-1:0] r_phase;

`ifdef TC_PED_EN
    logic r_ped_pend;
    logic r_walk_to_b;
    logic r_walk;
    assign w_ped = r_ped_pend;
`else
    assign w_ped = 1'b0;
`endif

    // A pending pedestrian counts as demand against whichever street is green
    assign w_dem_a = T_A | w_ped;
    assign w_dem_b = T_B | w_ped;
    assign w_clr   = (w_next != r_state);

    tc_dwell_timer #(
        .CNT_W (CNT_W),
        .LIMIT (SAT)
    ) u_dwell (
        .i_clk   (CLK),
        .i_rst_n (R),
        .i_clr   (w_clr),
        .o_cnt   (w_cnt)
    );

    // Next-phase selection from dwell count and street demand
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_AG: if (w_dem_b && ((w_cnt >= C_GMIN && !T_A) || w_cnt >= C_GMAX)) w_next = S_AY;
            S_AY: if (w_cnt == C_YEL) w_next = S_RA;
            S_RA: if (w_cnt == C_RED) w_next = w_ped ? tc_state_e'(PHASE_W'(6)) : S_BG;
            S_BG: if (w_dem_a && ((w_cnt >= C_GMIN && !T_B) || w_cnt >= C_GMAX)) w_next = S_BY;
            S_BY: if (w_cnt == C_YEL) w_next = S_RB;
            S_RB: if (w_cnt == C_RED) w_next = w_ped ? tc_state_e'(PHASE_W'(6)) : S_AG;
`ifdef TC_PED_EN
            S_WALK: if (w_cnt == C_WALK) w_next = r_walk_to_b ? S_BG : S_AG;
`endif
            default: w_next = S_RB;
        endcase
    end

    // State and lamp registers load together so lamps never lag the phase
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_state <= S_RB;
            r_l_a   <= RED;
            r_l_b   <= RED;
            r_phase <= S_RB;
        end else begin
            r_state <= w_next;
            r_l_a   <= lamp_a(w_next);
            r_l_b   <= lamp_b(w_next);
            r_phase <= w_next;
        end
    end

`ifdef TC_PED_EN
    // Sticky pedestrian request, consumed on walk entry; direction after walk is captured at entry
    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            r_ped_pend  <= 1'b0;
            r_walk_to_b <= 1'b0;
            r_walk      <= 1'b0;
        end else begin
            r_walk <= (w_next == S_WALK);
            if (w_next == S_WALK && r_state != S_WALK) begin
                r_ped_pend  <= 1'b0;
                r_walk_to_b <= (r_state == S_RA);
            end else if (P_REQ) begin
                r_ped_pend <= 1'b1;
            end
        end
    end

    assign WALK = r_walk;
`endif

    assign L_A   = r_l_a;
    assign L_B   = r_l_b;
    assign PHASE = r_phase;

endmodule

// File: tb/tb_tc_phase_scheduler.sv
// tb/tb_tc_phase_scheduler.sv - self-checking bench for tc_phase_scheduler (TC_PED_EN enables walk checks)
module tb_tc_phase_scheduler;

    localparam logic [2:0] P_AG = 3'd0, P_AY = 3'd1, P_RA = 3'd2;
    localparam logic [2:0] P_BG = 3'd3, P_BY = 3'd4, P_RB = 3'd5, P_WK = 3'd6;
    localparam logic [2:0] LR = 3'b100, LY = 3'b010, LG = 3'b001;

    logic       CLK = 1'b0;
    logic       R = 1'b0;
    logic       T_A = 1'b0;
    logic       T_B = 1'b0;
    logic [2:0] L_A, L_B, PHASE;
    logic       pr_drv = 1'b0;
`ifdef TC_PED_EN
    logic       WALK;
`endif

    typedef struct {
        logic [2:0] la;
        logic [2:0] lb;
        logic [2:0] ph;
        logic       walk;
    } exp_t;

    typedef struct {
        bit         rn;
        bit         ta;
        bit         tb;
        logic [2:0] la;
        logic [2:0] lb;
        logic [2:0] ph;
    } vec_t;

    exp_t sb[$];
    vec_t tv[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    tc_phase_scheduler dut (
        .CLK   (CLK),
        .R     (R),
        .T_A   (T_A),
        .T_B   (T_B),
`ifdef TC_PED_EN
        .P_REQ (pr_drv),
`endif
        .L_A   (L_A),
        .L_B   (L_B),
        .PHASE (PHASE)
`ifdef TC_PED_EN
        ,
        .WALK  (WALK)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic exp_t exp_of(input logic [2:0] ph);
        exp_t e;
        e.ph = ph;
        e.walk = (ph == P_WK);
        case (ph)
            P_AG:    begin e.la = LG; e.lb = LR; end
            P_AY:    begin e.la = LY; e.lb = LR; end
            P_BG:    begin e.la = LR; e.lb = LG; end
            P_BY:    begin e.la = LR; e.lb = LY; end
            default: begin e.la = LR; e.lb = LR; end
        endcase
        return e;
    endfunction

    task automatic cmp3(input string name, input logic [2:0] act, input logic [2:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty got %b expected entry", name, PHASE);
            return;
        end
        e = sb.pop_front();
        cmp3({name, ".L_A"}, L_A, e.la);
        cmp3({name, ".L_B"}, L_B, e.lb);
        cmp3({name, ".PHASE"}, PHASE, e.ph);
`ifdef TC_PED_EN
        cmp3({name, ".WALK"}, {2'b00, WALK}, {2'b00, e.walk});
`endif
    endtask

    task automatic step(input bit rn, input bit ta, input bit tb, input bit pr,
                        input exp_t e, input string name);
        R = rn; T_A = ta; T_B = tb; pr_drv = pr;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        check(name);
    endtask

    task automatic phases(input bit ta, input bit tb, input logic [2:0] ph, input int n,
                          input string name);
        for (int i = 0; i < n; i++) step(1'b1, ta, tb, 1'b0, exp_of(ph), name);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, exp_of(P_RB), "reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, exp_of(P_RB), "reset");
    endtask

    initial begin
        // Reset, then T_B demand only: 4 green, 2 yellow, 1 all-red, B green
        tv.push_back('{1'b0, 1'b0, 1'b0, LR, LR, P_RB});
        tv.push_back('{1'b0, 1'b0, 1'b0, LR, LR, P_RB});
        for (int i = 0; i < 4; i++) tv.push_back('{1'b1, 1'b0, 1'b1, LG, LR, P_AG});
        for (int i = 0; i < 2; i++) tv.push_back('{1'b1, 1'b0, 1'b1, LY, LR, P_AY});
        tv.push_back('{1'b1, 1'b0, 1'b1, LR, LR, P_RA});
        for (int i = 0; i < 3; i++) tv.push_back('{1'b1, 1'b0, 1'b1, LR, LG, P_BG});

        for (int i = 0; i < tv.size(); i++) begin
            exp_t e;
            e.la = tv[i].la; e.lb = tv[i].lb; e.ph = tv[i].ph; e.walk = 1'b0;
            step(tv[i].rn, tv[i].ta, tv[i].tb, 1'b0, e, $sformatf("vec%0d", i));
        end

        // No demand: A green held indefinitely
        do_reset();
        phases(1'b0, 1'b0, P_AG, 20, "idle_green");

        // Both streets demand: max-green alternation A,B,A
        do_reset();
        phases(1'b1, 1'b1, P_AG, 8, "both_ag");
        phases(1'b1, 1'b1, P_AY, 2, "both_ay");
        phases(1'b1, 1'b1, P_RA, 1, "both_ra");
        phases(1'b1, 1'b1, P_BG, 8, "both_bg");
        phases(1'b1, 1'b1, P_BY, 2, "both_by");
        phases(1'b1, 1'b1, P_RB, 1, "both_rb");
        phases(1'b1, 1'b1, P_AG, 8, "both_ag2");
        phases(1'b1, 1'b1, P_AY, 1, "both_ay2");

        // One-cycle T_B pulse at cnt=1 while A busy is ignored; late demand past max exits at once
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, exp_of(P_AG), "pulse_entry");
        step(1'b1, 1'b1, 1'b0, 1'b0, exp_of(P_AG), "pulse_cnt0");
        step(1'b1, 1'b1, 1'b1, 1'b0, exp_of(P_AG), "pulse_cnt1");
        phases(1'b1, 1'b0, P_AG, 12, "pulse_hold");
        step(1'b1, 1'b1, 1'b1, 1'b0, exp_of(P_AY), "late_demand");

        // Asynchronous reset in the middle of yellow, then a clean restart of A green
        do_reset();
        phases(1'b0, 1'b1, P_AG, 4, "ry_ag");
        phases(1'b0, 1'b1, P_AY, 1, "ry_ay");
        #3;
        R = 1'b0;
        #1;
        cmp3("async_rst.L_A", L_A, LR);
        cmp3("async_rst.L_B", L_B, LR);
        cmp3("async_rst.PHASE", PHASE, P_RB);
        step(1'b0, 1'b0, 1'b1, 1'b0, exp_of(P_RB), "ry_hold");
        phases(1'b0, 1'b1, P_AG, 4, "ry_restart");
        phases(1'b0, 1'b1, P_AY, 2, "ry_ay2");
        phases(1'b0, 1'b1, P_RA, 1, "ry_ra");
        phases(1'b0, 1'b1, P_BG, 2, "ry_bg");

`ifdef TC_PED_EN
        // Pedestrian pulse during A green: walk phase between A and B, request consumed
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, exp_of(P_AG), "ped_entry");
        step(1'b1, 1'b0, 1'b0, 1'b1, exp_of(P_AG), "ped_pulse");
        phases(1'b0, 1'b0, P_AG, 2, "ped_ag");
        phases(1'b0, 1'b0, P_AY, 2, "ped_ay");
        phases(1'b0, 1'b0, P_RA, 1, "ped_ra");
        phases(1'b0, 1'b0, P_WK, 3, "ped_walk");
        phases(1'b0, 1'b0, P_BG, 6, "ped_bg");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tc_phase_scheduler.md
# tc_phase_scheduler

Timed phase scheduler for the two-street traffic-light intersection: arbitrates right-of-way between street A and street B from traffic sensors T_A/T_B, and sequences green -> yellow -> all-red -> opposite green with programmable dwell times. It replaces the untimed Mealy controller as the block driving the L_A/L_B lamp outputs. Minimum- and maximum-green limits give fairness when both streets demand service.

## Interface
- GREEN_MIN, 4, minimum green dwell in cycles (>=1)
- GREEN_MAX, 8, green dwell after which a waiting opposite demand forces a change (>=GREEN_MIN)
- YELLOW_T, 2, yellow dwell in cycles (>=1)
- ALLRED_T, 1, all-red clearance dwell in cycles (>=1)
- WALK_T, 3, pedestrian walk dwell in cycles (>=1; used only with TC_PED_EN)
- CNT_W, 8, dwell counter width; must hold max(GREEN_MAX, YELLOW_T, ALLRED_T, WALK_T)

- CLK  in  1  clock, all state on rising edge
- R  in  1  reset, asynchronous, active-low
- T_A  in  1  street A traffic present, synchronous to CLK
- T_B  in  1  street B traffic present, synchronous to CLK
- L_A  out  3  street A lamps {red, yellow, green}, one-hot
- L_B  out  3  street B lamps {red, yellow, green}, one-hot
- PHASE  out  3  current state code (debug)
- P_REQ  in  1  pedestrian button pulse (TC_PED_EN only)
- WALK  out  1  pedestrian walk lamp (TC_PED_EN only)

## Operation
- Lamp codes: RED=3'b100, YELLOW=3'b010, GREEN=3'b001.
- States: S_AG (A green/B red), S_AY (A yellow/B red), S_RA (all red, next B), S_BG, S_BY, S_RB (all red, next A), S_WALK (macro only; all red, WALK=1).
- Dwell counter cnt clears to 0 on every state entry, increments each cycle, saturates at GREEN_MAX-1.
- S_AG -> S_AY when demand_B && ((cnt>=GREEN_MIN-1 && !T_A) || cnt>=GREEN_MAX-1). demand_B = T_B (OR ped_pend with macro). No demand: stay green indefinitely.
- S_BG -> S_BY symmetric with A/B swapped.
- S_AY -> S_RA, S_BY -> S_RB when cnt==YELLOW_T-1; no early exit, sensors ignored.
- S_RA -> S_BG, S_RB -> S_AG when cnt==ALLRED_T-1 (macro: to S_WALK instead if ped_pend).
- Reset (R=0): state S_RB, cnt=0, L_A=L_B=RED, PHASE=S_RB code, WALK=0, ped_pend=0. First green after reset is always A.
- Reset mid-phase (including mid-yellow) aborts immediately to all-red; no lamp other than RED is ever driven during or right after reset.
- Invariant: at most one street non-RED in any cycle; never GREEN->GREEN without YELLOW and all-red between.

## Timing
- L_A, L_B, PHASE, WALK are registered decodes of next state; they change on the same edge as the state register, zero cycles of decode lag.
- Sensor sampled on edge k decides the transition at edge k; lamps change at edge k.
- Green lasts >= GREEN_MIN cycles; with continuous opposite demand and own demand, exactly GREEN_MAX cycles.
- Yellow exactly YELLOW_T cycles; all-red exactly ALLRED_T cycles; walk exactly WALK_T cycles.
- Simultaneous T_A=T_B=1 from reset: phases alternate A,B,A with GREEN_MAX greens.

## Configuration
- TC_PED_EN defined: P_REQ/WALK ports exist; P_REQ=1 sets ped_pend (sticky) in any state; ped_pend counts as opposite demand in both green states; on all-red exit with ped_pend=1 enter S_WALK, remember next direction, after WALK_T go to that green; ped_pend clears on S_WALK entry; P_REQ during S_WALK re-sets it for the next cycle.
- TC_PED_EN undefined: ports absent, S_WALK unreachable and not encoded, WALK logic removed.

## Structure
- Package tc_pkg: state enum/codes, lamp constants RED/YELLOW/GREEN, PHASE code widths.
- Sub-module tc_dwell_timer: CNT_W counter with synchronous clear, saturate limit, async active-low reset.
- Top holds state register, next-state logic, lamp decode, ped_pend (macro).

## Test plan
- Reset hold then release, T_A=T_B=0 -> 1 cycle L_A=L_B=100, then L_A=001/L_B=100 held indefinitely.
- T_B=1, T_A=0 from release -> A green 4 cycles, L_A=010 2 cycles, all-red 1 cycle, then L_B=001.
- T_A=T_B=1 continuous -> greens 8 cycles each, alternating A,B,A, 2 yellow + 1 all-red between.
- T_B pulse 1 cycle at green cnt=1 while T_A=1 -> no change (demand absent at cnt>=3 and not max).
- R asserted mid S_AY -> same edge L_A=L_B=100; after release A green restarts with cnt=0.
- TC_PED_EN: P_REQ pulse during A green, no sensors -> A green 4 cycles, yellow 2, all-red 1, WALK=1 for 3 cycles with all red, then B green, ped_pend=0.
